// File: rtl/ram_lsu.sv
// ram_lsu: load/store initiator and sole master of the 256x16 data RAM port.
// Single-word stores and 1-16 word burst loads arrive on a valid/ready request
// channel; load words are returned one at a time on a valid/ready response
// channel. Each RAM access takes one cycle, so stores complete in 2 cycles and
// bursts deliver one word every 2 cycles when the consumer never stalls.
module ram_lsu #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    // RAM port
    output logic              write_enable,
    output logic              ram_read,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [DATA_W-1:0] r_cur_wdata;
    logic [LEN_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_valid;

    logic              w_accept;
    logic              w_rsp_fire;
    logic              w_last_word;
    logic              w_write_enable;
    logic              w_ram_read;
    logic [DATA_W-1:0] w_write_data;

    // Handshake qualifiers shared by the FSM and the datapath.
    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_rsp_fire  = r_rsp_valid && rsp_ready;
    assign w_last_word = (r_remaining == LEN_ZERO);

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one RAM cycle per WRITE/READ, RESP waits for the consumer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = req_write ? ST_WRITE : ST_READ;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_next_state = ST_IDLE;
            end
            ST_READ: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (w_rsp_fire) begin
                    w_next_state = w_last_word ? ST_IDLE : ST_READ;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: request latch, burst address/count, response holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_addr  <= ADDR_ZERO;
            r_cur_wdata <= DATA_ZERO;
            r_remaining <= LEN_ZERO;
            r_rsp_data  <= DATA_ZERO;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cur_addr <= req_addr;
                        if (req_write) begin
                            r_cur_wdata <= req_wdata;
                        end else begin
                            r_remaining <= req_len;
                        end
                    end
                end
                ST_READ: begin
                    r_rsp_data  <= data_out;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 1'b0;
                        if (!w_last_word) begin
                            // wraps modulo 2^ADDR_W by construction
                            r_cur_addr  <= r_cur_addr + ADDR_ONE;
                            r_remaining <= r_remaining - LEN_ONE;
                        end
                    end
                end
                default: begin
                    r_rsp_valid <= r_rsp_valid;
                end
            endcase
        end
    end

    // Moore output decode: strobes depend on state only, so write and read are exclusive.
    always_comb begin
        w_write_enable = 1'b0;
        w_ram_read     = 1'b0;
        w_write_data   = DATA_ZERO;
        case (r_state)
            ST_WRITE: begin
                w_write_enable = 1'b1;
                w_write_data   = r_cur_wdata;
            end
            ST_READ: begin
                w_ram_read = 1'b1;
            end
            default: begin
                w_write_enable = 1'b0;
                w_ram_read     = 1'b0;
                w_write_data   = DATA_ZERO;
            end
        endcase
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_last     = r_rsp_valid && (r_state == ST_RESP) && w_last_word;
    assign write_enable = w_write_enable;
    assign ram_read     = w_ram_read;
    assign address      = r_cur_addr;
    assign write_data   = w_write_data;

endmodule

// File: tb/tb_ram_lsu.sv
// Self-checking bench for ram_lsu: a behavioural RAM on the port, a shadow
// memory image as the reference, a vector table for the directed plan and
// hand-written sequences for busy rejection and reset mid-burst, then random
// traffic with random consumer backpressure.
module tb_ram_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_len;
    logic        rsp_valid, rsp_ready, rsp_last, busy;
    logic [15:0] rsp_data;
    logic        write_enable, ram_read;
    logic [7:0]  address;
    logic [15:0] write_data, data_out;

    logic [15:0] ram_mem   [256];
    logic [15:0] model_mem [256];

    int total = 0;
    int bad   = 0;

    ram_lsu #(.ADDR_W(8), .DATA_W(16), .LEN_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy),
        .write_enable(write_enable), .ram_read(ram_read), .address(address),
        .write_data(write_data), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // behavioural RAM: writes on the rising edge, combinational read
    always @(posedge clk) begin
        if (write_enable) ram_mem[address] <= write_data;
    end
    assign data_out = ram_read ? ram_mem[address] : 16'h0000;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [3:0]  len;
        int          stall_word;
        int          stall_n;
        logic [15:0] exp_first;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // one clock, sampled 1 time unit after the edge, with the strobe exclusion check
    task automatic tick();
        @(posedge clk);
        #1;
        check("strobe_excl", {31'd0, write_enable && ram_read}, 32'd0);
    endtask

    // present a request and return 1 unit after the accepting edge
    task automatic send_req(input bit wr, input logic [7:0] a, input logic [15:0] d, input logic [3:0] len);
        int n;
        req_write = wr; req_addr = a; req_wdata = d; req_len = len; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [7:0] a, input logic [15:0] d);
        send_req(1'b1, a, d, 4'd0);
        check("st_we", {31'd0, write_enable}, 32'd1);
        check("st_addr", {24'd0, address}, {24'd0, a});
        check("st_wdata", {16'd0, write_data}, {16'd0, d});
        check("st_busy", {31'd0, busy}, 32'd1);
        model_mem[a] = d;
        tick();
        check("st_we_one_cycle", {31'd0, write_enable}, 32'd0);
        check("st_idle", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    // load with a stall of stall_n cycles on word stall_word; returns the first word seen
    task automatic do_load(input logic [7:0] a, input logic [3:0] len, input int stall_word,
                           input int stall_n, output logic [15:0] first);
        logic [7:0]  ea;
        logic [15:0] ed;
        send_req(1'b0, a, 16'h0000, len);
        check("ld_ram_read", {31'd0, ram_read}, 32'd1);
        check("ld_addr", {24'd0, address}, {24'd0, a});
        tick();
        check("ld_latency", {31'd0, rsp_valid}, 32'd1);
        first = rsp_data;
        for (int i = 0; i <= int'(len); i++) begin
            ea = 8'(int'(a) + i);
            ed = model_mem[ea];
            wait_rsp();
            check("ld_data", {16'd0, rsp_data}, {16'd0, ed});
            check("ld_last", {31'd0, rsp_last}, {31'd0, i == int'(len)});
            if (i == stall_word) begin
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check("stall_valid", {31'd0, rsp_valid}, 32'd1);
                    check("stall_data", {16'd0, rsp_data}, {16'd0, ed});
                end
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            if (i < int'(len)) begin
                check("burst_ram_read", {31'd0, ram_read}, 32'd1);
                check("burst_addr", {24'd0, address}, {24'd0, 8'(int'(a) + i + 1)});
            end else begin
                check("burst_done", {31'd0, req_ready}, 32'd1);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] first;
        logic [7:0]  ra;
        logic [3:0]  rl;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i]   = 16'h0000;
            model_mem[i] = 16'h0000;
        end
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000;
        req_len = 4'd0; rsp_ready = 1'b0;

        // reset then idle
        reset = 1'b1;
        tick();
        tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
        check("rst_we", {31'd0, write_enable}, 32'd0);
        check("rst_rd", {31'd0, ram_read}, 32'd0);
        check("rst_addr", {24'd0, address}, 32'd0);
        check("rst_wdata", {16'd0, write_data}, 32'd0);
        reset = 1'b0;
        tick();

        // directed vector table
        vecs[0] = '{1'b1, 8'h00, 16'h4002, 4'd0, -1, 0, 16'h0000};
        vecs[1] = '{1'b0, 8'h00, 16'h0000, 4'd0, -1, 0, 16'h4002};
        vecs[2] = '{1'b1, 8'h10, 16'h0001, 4'd0, -1, 0, 16'h0000};
        vecs[3] = '{1'b1, 8'h11, 16'h0002, 4'd0, -1, 0, 16'h0000};
        vecs[4] = '{1'b1, 8'h12, 16'h0003, 4'd0, -1, 0, 16'h0000};
        vecs[5] = '{1'b1, 8'h13, 16'h0004, 4'd0, -1, 0, 16'h0000};
        vecs[6] = '{1'b0, 8'h10, 16'h0000, 4'd3,  1, 3, 16'h0001};
        vecs[7] = '{1'b1, 8'hFF, 16'hAAAA, 4'd0, -1, 0, 16'h0000};
        vecs[8] = '{1'b1, 8'h00, 16'h5555, 4'd0, -1, 0, 16'h0000};
        vecs[9] = '{1'b0, 8'hFF, 16'h0000, 4'd1, -1, 0, 16'hAAAA};
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wr) begin
                do_store(vecs[v].addr, vecs[v].data);
            end else begin
                do_load(vecs[v].addr, vecs[v].len, vecs[v].stall_word, vecs[v].stall_n, first);
                check("tbl_first_word", {16'd0, first}, {16'd0, vecs[v].exp_first});
            end
        end

        // busy rejection: a store held on the request channel during a 4-word burst
        send_req(1'b0, 8'h10, 16'h0000, 4'd3);
        req_write = 1'b1; req_addr = 8'h20; req_wdata = 16'hBEEF; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 20 && !rsp_valid; n++) begin
                check("busy_req_ready", {31'd0, req_ready}, 32'd0);
                check("busy_no_we", {31'd0, write_enable}, 32'd0);
                tick();
            end
            check("busy_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("busy_rsp_data", {16'd0, rsp_data}, {16'd0, model_mem[8'(8'h10 + i)]});
            check("busy_req_ready_rsp", {31'd0, req_ready}, 32'd0);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        check("busy_release_ready", {31'd0, req_ready}, 32'd1);
        check("busy_release_we", {31'd0, write_enable}, 32'd0);
        tick();
        req_valid = 1'b0;
        check("busy_store_we", {31'd0, write_enable}, 32'd1);
        check("busy_store_addr", {24'd0, address}, 32'h20);
        check("busy_store_data", {16'd0, write_data}, 32'hBEEF);
        model_mem[8'h20] = 16'hBEEF;
        tick();
        check("busy_store_done", {31'd0, write_enable}, 32'd0);

        // reset during the second word of an 8-word burst
        for (int i = 0; i < 8; i++) do_store(8'(8'h30 + i), 16'(16'hC000 + i));
        send_req(1'b0, 8'h30, 16'h0000, 4'd7);
        wait_rsp();
        check("mid_w1", {16'd0, rsp_data}, 32'hC000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        wait_rsp();
        check("mid_w2", {16'd0, rsp_data}, 32'hC001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_addr", {24'd0, address}, 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_no_words", {31'd0, rsp_valid}, 32'd0);
            check("mid_no_read", {31'd0, ram_read}, 32'd0);
        end
        rsp_ready = 1'b0;
        do_load(8'h32, 4'd2, -1, 0, first);
        check("mid_after_load", {16'd0, first}, 32'hC002);

        // random traffic against the shadow memory
        for (int t = 0; t < 60; t++) begin
            ra = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_store(ra, 16'($urandom));
            end else begin
                rl = 4'($urandom_range(0, 15));
                do_load(ra, rl, $urandom_range(0, int'(rl)), $urandom_range(0, 3), first);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
